frame_dump_tx: RTL and testbench
================================

// Module: frame_dump_tx
// PURPOSE
// - Streams the pixel frame buffer back out over the UART link: reads each 24-bit pixel from RAM
//   and sends it as 3 bytes to the UART transmitter.
// - Counterpart of the serial pixel loader: byte order and addressing mirror the receive side,
//   so a dumped frame can be re-sent unchanged and reloads identically.
// - Sits between the frame-buffer RAM read port and the uart_tx byte interface.
// PARAMETERS
// - PIXEL_COUNT   172800  number of pixels in the frame; addresses 0..PIXEL_COUNT-1
// - RAM_LATENCY   1       clocks from ram_addr valid to ram_data valid; legal range 1..3
// - ADDR_W        $clog2(PIXEL_COUNT)  derived localparam, not overridable
// PORTS
// - clk       in   1       system clock
// - reset     in   1       synchronous, active-high reset
// - start     in   1       pulse; begins a full-frame dump from address 0 (ignored while busy)
// - ram_addr  out  ADDR_W  frame-buffer read address
// - ram_data  in   24      pixel read from ram_addr, RAM_LATENCY clocks later
// - tx_busy   in   1       uart_tx busy; high from the clock after tx_start until its stop bit ends
// - tx_start  out  1       one-clock pulse requesting transmission of tx_data
// - tx_data   out  8       byte to transmit; held stable from tx_start until tx_busy falls
// - busy      out  1       high from the clock after an accepted start until done
// - done      out  1       one-clock pulse after the last byte of pixel PIXEL_COUNT-1 completes
// BEHAVIOUR
// - Reset values: ram_addr=0, tx_start=0, tx_data=0, busy=0, done=0, state=IDLE, pixel reg=0.
//   Reset mid-frame aborts immediately. No partial byte is re-sent. tx_start is never high in the
//   clock after reset.
// - FSM states: IDLE, RD_WAIT, LOAD, SEND, ACK, DRAIN, NEXT, FINISH.
//   IDLE   : on start -> ram_addr=0, latency counter=0, busy=1 -> RD_WAIT.
//   RD_WAIT: count RAM_LATENCY clocks -> LOAD.
//   LOAD   : capture ram_data into 24-bit pixel reg, byte_idx=0 -> SEND.
//   SEND   : wait while tx_busy=1. When tx_busy=0: tx_start=1 for one clock, with
//            tx_data=pixel[8*byte_idx +: 8] -> ACK.
//   ACK    : one-clock guard so tx_busy can assert -> DRAIN.
//   DRAIN  : wait for tx_busy=0. If byte_idx<2: byte_idx+1 -> SEND; else -> NEXT.
//   NEXT   : if ram_addr==PIXEL_COUNT-1 -> FINISH; else ram_addr+1, counter=0 -> RD_WAIT.
//   FINISH : done=1 for one clock, busy=0, ram_addr=0 -> IDLE.
// - Byte order per pixel: [7:0] first, then [15:8], then [23:16]. Matches the receive-side assembly.
// - Minimum clocks per pixel: RAM_LATENCY+1 (read) plus 3x(SEND+ACK+DRAIN) plus 1 (NEXT).
//   In practice the UART byte time dominates.
// - ram_addr is held constant from RD_WAIT through NEXT. The pixel reg is written only in LOAD, so
//   RAM writes to the current address during transmission do not corrupt bytes in flight.
// - start while busy=1 is ignored and not queued. start in the same clock as FINISH is ignored.
//   A start is accepted only in IDLE.
// - Address arithmetic is ADDR_W bits. ram_addr never exceeds PIXEL_COUNT-1 and returns to 0 at end.
// - tx_busy already high when SEND is entered: stay in SEND, never pulse tx_start into a busy TX.
// - PIXEL_COUNT=1 is legal: 3 bytes are sent, then done.
// STRUCTURE
// - Shared package frame_dump_pkg holds:
//   - state enum typedef (logic [2:0])
//   - BYTES_PER_PIXEL=3 constant
//   - byte-index typedef (logic [1:0])
// - The receive-side loader imports BYTES_PER_PIXEL from the same package.
// - Single flat module with one registered FSM and registered outputs. No sub-module is needed.
//   The uart_tx instance lives in the parent.
// TESTING
// Bench setup: PIXEL_COUNT=4, RAM_LATENCY=1, behavioural RAM, uart_tx model with 10-clock busy per byte.
// - Frame: RAM={0x030201,0x060504,0x090807,0x0C0B0A}; start pulse -> tx_data sequence 01..0C
//   in order, ram_addr 0,1,2,3, one done pulse, busy falls with done, ram_addr=0 afterwards.
// - Handshake: TX model holds tx_busy=1 for 50 extra clocks -> no tx_start while tx_busy=1;
//   tx_data stable through each busy window; exactly 12 tx_start pulses in total.
// - Ignored start: second start pulse at the 5th byte -> still exactly 12 bytes and one done;
//   a start 2 clocks after done -> a new full 12-byte dump.
// - Reset mid-frame: assert reset during byte 7 -> next clock tx_start=0, busy=0, ram_addr=0;
//   a new start re-sends from byte 01.
// - Latency/edge: RAM_LATENCY=3 and PIXEL_COUNT=1 with RAM[0]=0xA5B6C7 -> bytes C7,B6,A5 then done;
//   the first pixel is captured exactly 3 clocks after ram_addr is driven.

Source files
------------

// File: rtl/frame_dump_pkg.sv
// Shared definitions for the frame-buffer serial link (dump and load sides).
package frame_dump_pkg;

    // Bytes sent per 24-bit pixel; the receive-side loader uses the same value.
    localparam int BYTES_PER_PIXEL = 3;

    // Dump FSM states.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_WAIT = 3'd1,
        LOAD    = 3'd2,
        SEND    = 3'd3,
        ACK     = 3'd4,
        DRAIN   = 3'd5,
        NEXT    = 3'd6,
        FINISH  = 3'd7
    } fd_state_e;

    // Index of the byte within a pixel (0 = bits [7:0]).
    typedef logic [1:0] byte_idx_t;

    // Select one byte of a pixel, least-significant byte first.
    function automatic logic [7:0] pixel_byte(input logic [23:0] pixel, input byte_idx_t idx);
        case (idx)
            2'd0:    pixel_byte = pixel[7:0];
            2'd1:    pixel_byte = pixel[15:8];
            2'd2:    pixel_byte = pixel[23:16];
            default: pixel_byte = 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/frame_dump_tx.sv
// Streams the pixel frame buffer out over the UART byte interface:
// each 24-bit pixel is read from RAM and sent as three bytes, LSB first.
module frame_dump_tx
    import frame_dump_pkg::*;
#(
    parameter int  PIXEL_COUNT = 172800,
    parameter int  RAM_LATENCY = 1,
    // A single-pixel frame still needs a 1-bit address port.
    localparam int ADDR_W      = (PIXEL_COUNT > 1) ? $clog2(PIXEL_COUNT) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [23:0]       ram_data,
    input  logic              tx_busy,
    output logic              tx_start,
    output logic [7:0]        tx_data,
    output logic              busy,
    output logic              done
);

    localparam int                LAT_W     = 2;
    localparam logic [LAT_W-1:0]  LAT_LAST  = LAT_W'(RAM_LATENCY - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(PIXEL_COUNT - 1);
    localparam byte_idx_t         IDX_LAST  = byte_idx_t'(BYTES_PER_PIXEL - 1);

    fd_state_e         state_q,    state_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [LAT_W-1:0]  lat_cnt_q,  lat_cnt_d;
    logic [23:0]       pixel_q,    pixel_d;
    byte_idx_t         byte_idx_q, byte_idx_d;
    logic              tx_start_q, tx_start_d;
    logic [7:0]        tx_data_q,  tx_data_d;
    logic              busy_q,     busy_d;
    logic              done_q,     done_d;

    // Next-state and registered-output computation for the dump FSM.
    always_comb begin
        state_d    = state_q;
        ram_addr_d = ram_addr_q;
        lat_cnt_d  = lat_cnt_q;
        pixel_d    = pixel_q;
        byte_idx_d = byte_idx_q;
        tx_start_d = 1'b0;
        tx_data_d  = tx_data_q;
        busy_d     = busy_q;
        done_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    ram_addr_d = '0;
                    lat_cnt_d  = '0;
                    busy_d     = 1'b1;
                    state_d    = RD_WAIT;
                end else begin
                    state_d    = IDLE;
                end
            end
            RD_WAIT: begin
                // Address has been stable since entry; data is valid after RAM_LATENCY clocks.
                if (lat_cnt_q == LAT_LAST) begin
                    lat_cnt_d = '0;
                    state_d   = LOAD;
                end else begin
                    lat_cnt_d = lat_cnt_q + LAT_W'(1);
                end
            end
            LOAD: begin
                // Pixel is latched once so RAM writes during transmission cannot corrupt it.
                pixel_d    = ram_data;
                byte_idx_d = 2'd0;
                state_d    = SEND;
            end
            SEND: begin
                // Never launch a byte into a transmitter that is still busy.
                if (!tx_busy) begin
                    tx_start_d = 1'b1;
                    tx_data_d  = pixel_byte(pixel_q, byte_idx_q);
                    state_d    = ACK;
                end else begin
                    state_d    = SEND;
                end
            end
            ACK: begin
                // Gives the transmitter one clock to raise tx_busy.
                state_d = DRAIN;
            end
            DRAIN: begin
                if (!tx_busy) begin
                    if (byte_idx_q < IDX_LAST) begin
                        byte_idx_d = byte_idx_q + 2'd1;
                        state_d    = SEND;
                    end else begin
                        state_d    = NEXT;
                    end
                end else begin
                    state_d = DRAIN;
                end
            end
            NEXT: begin
                if (ram_addr_q == ADDR_LAST) begin
                    state_d = FINISH;
                end else begin
                    ram_addr_d = ram_addr_q + ADDR_W'(1);
                    lat_cnt_d  = '0;
                    state_d    = RD_WAIT;
                end
            end
            FINISH: begin
                done_d     = 1'b1;
                busy_d     = 1'b0;
                ram_addr_d = '0;
                state_d    = IDLE;
            end
            default: begin
                busy_d     = 1'b0;
                ram_addr_d = '0;
                state_d    = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset; reset aborts any frame in progress.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            ram_addr_q <= '0;
            lat_cnt_q  <= '0;
            pixel_q    <= 24'h000000;
            byte_idx_q <= 2'd0;
            tx_start_q <= 1'b0;
            tx_data_q  <= 8'h00;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ram_addr_q <= ram_addr_d;
            lat_cnt_q  <= lat_cnt_d;
            pixel_q    <= pixel_d;
            byte_idx_q <= byte_idx_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign ram_addr = ram_addr_q;
    assign tx_start = tx_start_q;
    assign tx_data  = tx_data_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_frame_dump_tx.sv
// Self-checking bench for frame_dump_tx: a 4-pixel, latency-1 instance and a
// 1-pixel, latency-3 instance, each with a behavioural RAM and UART model.
module tb_frame_dump_tx;

    typedef struct {
        logic [7:0] b;
        logic [1:0] addr;
    } exp_t;

    logic        clk;
    logic        reset;

    // Instance 0: PIXEL_COUNT=4, RAM_LATENCY=1
    logic        start0;
    logic [1:0]  ram_addr0;
    logic [23:0] ram_data0;
    logic        tx_busy0;
    logic        tx_start0;
    logic [7:0]  tx_data0;
    logic        busy0;
    logic        done0;

    // Instance 1: PIXEL_COUNT=1, RAM_LATENCY=3
    logic        start1;
    logic [0:0]  ram_addr1;
    logic [23:0] ram_data1;
    logic        tx_busy1;
    logic        tx_start1;
    logic [7:0]  tx_data1;
    logic        busy1;
    logic        done1;

    int vectors     = 0;
    int miscompares = 0;

    logic [23:0] mem0 [4];
    logic [23:0] mem1_0;
    logic        mem1_wr;
    logic [23:0] p1, p2;

    int          extra_hold;
    int          busy_cnt0, busy_cnt1;
    logic [7:0]  held_byte0;
    int          n_start0 = 0, n_done0 = 0;
    int          n_start1 = 0, n_done1 = 0;

    exp_t        sb0 [$];
    logic [7:0]  sb1 [$];

    frame_dump_tx #(.PIXEL_COUNT(4), .RAM_LATENCY(1)) u_dut0 (
        .clk      (clk),
        .reset    (reset),
        .start    (start0),
        .ram_addr (ram_addr0),
        .ram_data (ram_data0),
        .tx_busy  (tx_busy0),
        .tx_start (tx_start0),
        .tx_data  (tx_data0),
        .busy     (busy0),
        .done     (done0)
    );

    frame_dump_tx #(.PIXEL_COUNT(1), .RAM_LATENCY(3)) u_dut1 (
        .clk      (clk),
        .reset    (reset),
        .start    (start1),
        .ram_addr (ram_addr1),
        .ram_data (ram_data1),
        .tx_busy  (tx_busy1),
        .tx_start (tx_start1),
        .tx_data  (tx_data1),
        .busy     (busy1),
        .done     (done1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Registered RAM, one clock of read latency.
    always @(posedge clk) ram_data0 <= mem0[ram_addr0];

    // Three-stage RAM pipeline; RAM[0] can be written on the same edge a start is sampled.
    always @(posedge clk) begin
        if (mem1_wr) mem1_0 <= 24'hA5B6C7;
        p1        <= mem1_0;
        p2        <= p1;
        ram_data1 <= p2;
    end

    // UART model 0: busy for about 10 clocks plus extra_hold per byte.
    always @(posedge clk) begin
        if (reset) begin
            tx_busy0  <= 1'b0;
            busy_cnt0 <= 0;
        end else if (tx_start0 && !tx_busy0) begin
            tx_busy0  <= 1'b1;
            busy_cnt0 <= 9 + extra_hold;
        end else if (busy_cnt0 != 0) begin
            busy_cnt0 <= busy_cnt0 - 1;
        end else begin
            tx_busy0  <= 1'b0;
        end
    end

    // UART model 1: busy for about 10 clocks per byte.
    always @(posedge clk) begin
        if (reset) begin
            tx_busy1  <= 1'b0;
            busy_cnt1 <= 0;
        end else if (tx_start1 && !tx_busy1) begin
            tx_busy1  <= 1'b1;
            busy_cnt1 <= 9;
        end else if (busy_cnt1 != 0) begin
            busy_cnt1 <= busy_cnt1 - 1;
        end else begin
            tx_busy1  <= 1'b0;
        end
    end

    // Output monitor for instance 0: scoreboard pop, handshake and stability checks.
    always @(negedge clk) begin
        if (!reset && tx_start0) begin
            n_start0++;
            check("start_into_busy0", 32'(tx_busy0), 32'd0);
            vectors++;
            assert (sb0.size() != 0) else begin
                miscompares++;
                $error("FAIL extra_byte0: observed byte %0h expected none", tx_data0);
            end
            if (sb0.size() != 0) begin
                exp_t e;
                e = sb0.pop_front();
                check("tx_data0", 32'(tx_data0), 32'(e.b));
                check("ram_addr0", 32'(ram_addr0), 32'(e.addr));
            end
            held_byte0 = tx_data0;
        end
        if (!reset && tx_busy0) check("tx_data_stable0", 32'(tx_data0), 32'(held_byte0));
        if (!reset && done0) begin
            n_done0++;
            check("busy_at_done0", 32'(busy0), 32'd0);
            check("addr_at_done0", 32'(ram_addr0), 32'd0);
            check("sb_empty_at_done0", 32'(sb0.size()), 32'd0);
        end
    end

    // Output monitor for instance 1.
    always @(negedge clk) begin
        if (!reset && tx_start1) begin
            n_start1++;
            check("start_into_busy1", 32'(tx_busy1), 32'd0);
            vectors++;
            assert (sb1.size() != 0) else begin
                miscompares++;
                $error("FAIL extra_byte1: observed byte %0h expected none", tx_data1);
            end
            if (sb1.size() != 0) check("tx_data1", 32'(tx_data1), 32'(sb1.pop_front()));
        end
        if (!reset && done1) n_done1++;
    end

    task automatic push_frame0();
        for (int j = 0; j < 12; j++) begin
            exp_t e;
            e.b    = 8'(j + 1);
            e.addr = 2'(j / 3);
            sb0.push_back(e);
        end
    endtask

    task automatic pulse_start0();
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
    endtask

    task automatic wait_done0(input int budget);
        int n;
        n = 0;
        while (done0 !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("done0_timeout", 32'(done0), 32'd1);
    endtask

    task automatic wait_starts0(input int target, input int budget);
        int n;
        n = 0;
        while (n_start0 < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("start_count_timeout0", 32'(n_start0 >= target), 32'd1);
    endtask

    // Full dump on instance 0 with count checks after done.
    task automatic run_frame0(input string tag);
        int sbase, dbase;
        sbase = n_start0;
        dbase = n_done0;
        push_frame0();
        pulse_start0();
        wait_done0(4000);
        repeat (2) @(negedge clk);
        check({tag, "_bytes"}, 32'(n_start0 - sbase), 32'd12);
        check({tag, "_dones"}, 32'(n_done0 - dbase), 32'd1);
        check({tag, "_addr_end"}, 32'(ram_addr0), 32'd0);
    endtask

    initial begin
        int sbase, dbase, lat;

        reset      = 1'b1;
        start0     = 1'b0;
        start1     = 1'b0;
        mem1_wr    = 1'b0;
        mem1_0     = 24'h000000;
        extra_hold = 0;
        held_byte0 = 8'h00;
        mem0[0]    = 24'h030201;
        mem0[1]    = 24'h060504;
        mem0[2]    = 24'h090807;
        mem0[3]    = 24'h0C0B0A;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_tx_start", 32'(tx_start0), 32'd0);
        check("rst_tx_data", 32'(tx_data0), 32'd0);
        check("rst_busy", 32'(busy0), 32'd0);
        check("rst_done", 32'(done0), 32'd0);
        check("rst_ram_addr", 32'(ram_addr0), 32'd0);
        check("rst_busy1", 32'(busy1), 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Basic frame: bytes 01..0C, addresses 0..3, one done
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        check("busy_after_start", 32'(busy0), 32'd1);
        push_frame0();
        sbase = n_start0;
        dbase = n_done0;
        wait_done0(4000);
        repeat (2) @(negedge clk);
        check("frame_bytes", 32'(n_start0 - sbase), 32'd12);
        check("frame_dones", 32'(n_done0 - dbase), 32'd1);
        check("frame_addr_end", 32'(ram_addr0), 32'd0);

        // Slow transmitter: 50 extra busy clocks per byte
        extra_hold = 50;
        run_frame0("slow");
        extra_hold = 0;

        // Start during the 5th byte is ignored
        sbase = n_start0;
        dbase = n_done0;
        push_frame0();
        pulse_start0();
        wait_starts0(sbase + 5, 2000);
        pulse_start0();
        wait_done0(4000);
        @(negedge clk);
        // Two clocks after done: a new start is accepted
        pulse_start0();
        check("restart_busy", 32'(busy0), 32'd1);
        check("ignored_bytes", 32'(n_start0 - sbase), 32'd12);
        check("ignored_dones", 32'(n_done0 - dbase), 32'd1);
        push_frame0();
        sbase = n_start0;
        dbase = n_done0;
        wait_done0(4000);
        repeat (40) @(negedge clk);
        check("restart_bytes", 32'(n_start0 - sbase), 32'd12);
        check("restart_dones", 32'(n_done0 - dbase), 32'd1);
        check("idle_after", 32'(busy0), 32'd0);

        // Reset during byte 7 aborts; a new start re-sends from byte 01
        sbase = n_start0;
        push_frame0();
        pulse_start0();
        wait_starts0(sbase + 7, 2000);
        repeat (3) @(negedge clk);
        check("mid_addr_before_rst", 32'(ram_addr0), 32'd2);
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_tx_start", 32'(tx_start0), 32'd0);
        check("mid_rst_busy", 32'(busy0), 32'd0);
        check("mid_rst_addr", 32'(ram_addr0), 32'd0);
        check("mid_rst_tx_data", 32'(tx_data0), 32'd0);
        sb0.delete();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        run_frame0("after_rst");

        // Latency 3, single pixel: C7, B6, A5 then done
        sb1.push_back(8'hC7);
        sb1.push_back(8'hB6);
        sb1.push_back(8'hA5);
        start1  = 1'b1;
        mem1_wr = 1'b1;
        @(negedge clk);
        start1  = 1'b0;
        mem1_wr = 1'b0;
        lat = 0;
        while (tx_start1 !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        // RD_WAIT for 3 clocks, LOAD, SEND, then the registered tx_start
        check("lat3_first_tx_start", 32'(lat), 32'd5);
        lat = 0;
        while (done1 !== 1'b1 && lat < 1000) begin
            @(negedge clk);
            lat++;
        end
        check("lat3_done", 32'(done1), 32'd1);
        check("lat3_busy_at_done", 32'(busy1), 32'd0);
        repeat (2) @(negedge clk);
        check("lat3_bytes", 32'(n_start1), 32'd3);
        check("lat3_dones", 32'(n_done1), 32'd1);
        check("lat3_sb_empty", 32'(sb1.size()), 32'd0);
        check("lat3_addr_end", 32'(ram_addr1), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
